// File: rtl/hazard_forward_unit.sv
// rtl/hazard_forward_unit.sv - EX-stage forwarding selects, load-use stall and WB write-port tracking
module hazard_forward_unit #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [4:0]             mem_dest,
  input  logic                   mem_regwrite,
  input  logic [4:0]             ex_rs,
  input  logic [4:0]             ex_rt,
  input  logic                   ex_memread,
  input  logic [4:0]             id_rs,
  input  logic [4:0]             id_rt,
  output logic [1:0]             fwd_a,
  output logic [1:0]             fwd_b,
  output logic                   stall,
  output logic [4:0]             wb_dest,
  output logic                   wb_regwrite,
  output logic [STALL_CNT_W-1:0] stall_count
);

  // Forwarding select encoding seen by the ALU operand muxes
  localparam logic [1:0] SEL_IDEX = 2'b00;
  localparam logic [1:0] SEL_WB   = 2'b01;
  localparam logic [1:0] SEL_MEM  = 2'b10;

  localparam logic [STALL_CNT_W-1:0] CNT_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [STALL_CNT_W-1:0] CNT_MAX = {STALL_CNT_W{1'b1}};

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_t;

  state_t state;

  logic mem_fwd_ok;
  logic wb_fwd_ok;
  logic hazard;

  // Producers that can legally forward: writing, and not targeting $0
  always_comb begin
    mem_fwd_ok = mem_regwrite && (mem_dest != 5'd0);
    wb_fwd_ok  = wb_regwrite && (wb_dest != 5'd0);
  end

  // Operand A source: MEM result wins over WB result when both match
  always_comb begin
    fwd_a = SEL_IDEX;
    if (mem_fwd_ok && (mem_dest == ex_rs)) begin
      fwd_a = SEL_MEM;
    end else if (wb_fwd_ok && (wb_dest == ex_rs)) begin
      fwd_a = SEL_WB;
    end
  end

  // Operand B source, same priority as operand A
  always_comb begin
    fwd_b = SEL_IDEX;
    if (mem_fwd_ok && (mem_dest == ex_rt)) begin
      fwd_b = SEL_MEM;
    end else if (wb_fwd_ok && (wb_dest == ex_rt)) begin
      fwd_b = SEL_WB;
    end
  end

  // Load in EX whose result is needed by the instruction in ID
  always_comb begin
    hazard = ex_memread && (ex_rt != 5'd0) &&
             ((ex_rt == id_rs) || (ex_rt == id_rt));
  end

  // Stall only from IDLE; the reset gate keeps it low while rst_n is held
  always_comb begin
    stall = rst_n && (state == IDLE) && hazard;
  end

  // One bubble per load: a stall cycle is always followed by a return to IDLE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    state <= hazard ? STALL : IDLE;
        STALL:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // MEM-to-WB stage always advances; stall holds only the front end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_dest     <= 5'd0;
      wb_regwrite <= 1'b0;
    end else begin
      wb_dest     <= mem_dest;
      wb_regwrite <= mem_regwrite;
    end
  end

  // Saturating count of issued stall cycles
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (stall && (stall_count != CNT_MAX)) begin
      stall_count <= stall_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb/tb_hazard_forward_unit.sv - scoreboard bench for hazard_forward_unit
module tb_hazard_forward_unit;

  logic       clk;
  logic       rst_n;
  logic [4:0] mem_dest;
  logic       mem_regwrite;
  logic [4:0] ex_rs;
  logic [4:0] ex_rt;
  logic       ex_memread;
  logic [4:0] id_rs;
  logic [4:0] id_rt;

  logic [1:0]  fwd_a, fwd_b;
  logic        stall;
  logic [4:0]  wb_dest;
  logic        wb_regwrite;
  logic [15:0] stall_count;

  logic [1:0]  s_fwd_a, s_fwd_b;
  logic        s_stall;
  logic [4:0]  s_wb_dest;
  logic        s_wb_regwrite;
  logic [1:0]  s_stall_count;

  hazard_forward_unit #(.STALL_CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .mem_dest(mem_dest), .mem_regwrite(mem_regwrite),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_memread(ex_memread), .id_rs(id_rs), .id_rt(id_rt),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall(stall), .wb_dest(wb_dest),
    .wb_regwrite(wb_regwrite), .stall_count(stall_count)
  );

  hazard_forward_unit #(.STALL_CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .mem_dest(mem_dest), .mem_regwrite(mem_regwrite),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_memread(ex_memread), .id_rs(id_rs), .id_rt(id_rt),
    .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .stall(s_stall), .wb_dest(s_wb_dest),
    .wb_regwrite(s_wb_regwrite), .stall_count(s_stall_count)
  );

  typedef struct {
    int fa;
    int fb;
    int st;
    int wd;
    int wr;
    int cnt;
    int cnt2;
  } exp_t;

  exp_t sb[$];
  int   tests;
  int   failed;

  // Reference state: what the pipeline looks like at the current cycle
  int m_wb_dest;
  int m_wb_rw;
  int m_prev_stall;
  int m_cnt;
  int m_cnt2;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp_v);
    tests++;
    if (act != exp_v) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare against the oldest expectation
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("fwd_a", int'(fwd_a), e.fa);
      chk("fwd_b", int'(fwd_b), e.fb);
      chk("stall", int'(stall), e.st);
      chk("wb_dest", int'(wb_dest), e.wd);
      chk("wb_regwrite", int'(wb_regwrite), e.wr);
      chk("stall_count", int'(stall_count), e.cnt);
      chk("sat_stall_count", int'(s_stall_count), e.cnt2);
      chk("sat_stall", int'(s_stall), e.st);
    end
  end

  function automatic int ref_fwd(int md, int mrw, int wd, int wrw, int src);
    if (mrw != 0 && md != 0 && md == src) return 2;
    if (wrw != 0 && wd != 0 && wd == src) return 1;
    return 0;
  endfunction

  // Apply one cycle of inputs, predict outputs, then advance the reference at the edge
  task automatic cyc(input int r, input int md, input int mrw, input int ers, input int ert,
                     input int emr, input int irs, input int irt);
    exp_t e;
    int   hz;
    rst_n        = r[0];
    mem_dest     = md[4:0];
    mem_regwrite = mrw[0];
    ex_rs        = ers[4:0];
    ex_rt        = ert[4:0];
    ex_memread   = emr[0];
    id_rs        = irs[4:0];
    id_rt        = irt[4:0];
    hz   = (emr != 0 && ert != 0 && (ert == irs || ert == irt)) ? 1 : 0;
    e.fa = ref_fwd(md, mrw, m_wb_dest, m_wb_rw, ers);
    e.fb = ref_fwd(md, mrw, m_wb_dest, m_wb_rw, ert);
    e.st = (r != 0 && hz != 0 && m_prev_stall == 0) ? 1 : 0;
    e.wd = m_wb_dest;
    e.wr = m_wb_rw;
    e.cnt  = m_cnt;
    e.cnt2 = m_cnt2;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (r == 0) begin
      m_wb_dest = 0; m_wb_rw = 0; m_prev_stall = 0; m_cnt = 0; m_cnt2 = 0;
    end else begin
      m_wb_dest    = md;
      m_wb_rw      = mrw;
      m_prev_stall = e.st;
      if (e.st != 0) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end
    end
  endtask

  initial begin
    int waited;
    tests = 0;
    failed = 0;
    rst_n = 1'b0;
    mem_dest = 5'd5; mem_regwrite = 1'b1;
    ex_rs = 5'd0; ex_rt = 5'd3; ex_memread = 1'b1;
    id_rs = 5'd3; id_rt = 5'd0;
    @(posedge clk);
    #1;
    m_wb_dest = 0; m_wb_rw = 0; m_prev_stall = 0; m_cnt = 0; m_cnt2 = 0;

    // Reset held with a live hazard and writer, then release
    cyc(0, 5, 1, 0, 3, 1, 3, 0);
    cyc(0, 5, 1, 0, 3, 1, 3, 0);
    cyc(1, 5, 1, 0, 3, 1, 3, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);

    // MEM forwarding, then the same producer seen from WB
    cyc(1, 8, 1, 8, 9, 0, 0, 0);
    cyc(1, 0, 0, 8, 9, 0, 0, 0);

    // MEM over WB priority, then $0 never forwarded
    cyc(1, 4, 1, 0, 0, 0, 0, 0);
    cyc(1, 4, 1, 4, 4, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0, 0, 0);

    // Load-use held three cycles, then five more stall opportunities for saturation
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 7, 1, 0, 7);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(1, 0, 0, 0, 7, 1, 7, 0);

    // Reset during the stall cycle, then a hazard right after release
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 6, 1, 6, 0);
    cyc(0, 0, 0, 0, 6, 1, 6, 0);
    cyc(1, 0, 0, 0, 6, 1, 6, 0);
    cyc(1, 0, 0, 0, 6, 1, 6, 0);

    // Randomized traffic over a small register window to provoke matches
    for (int i = 0; i < 1500; i++) begin
      cyc(($urandom_range(0, 63) == 0) ? 0 : 1,
          int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
          int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
          int'($urandom_range(0, 1)),
          int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
    end

    waited = 0;
    while (sb.size() > 0 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    #2;
    if (sb.size() > 0) begin
      tests++;
      failed++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
